// File: rtl/bubble_sort_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bubble_sort_pkg
// Purpose  : Shared select encodings and ALU op codes for the bubble-sort
//            datapath and its controller.
// Contents : m1/m2/m4 select codes, alu_op_t (ADD/SUB/PASS/CMP).
// Revision : 1.0 - initial release
// ============================================================================
package bubble_sort_pkg;

    // m1 : ALU in_1 source
    localparam logic [1:0] c_M1_I   = 2'b00;
    localparam logic [1:0] c_M1_J   = 2'b01;
    localparam logic [1:0] c_M1_K   = 2'b10;
    localparam logic [1:0] c_M1_A   = 2'b11;

    // m2 : ALU in_2 source
    localparam logic [1:0] c_M2_N1  = 2'b00;
    localparam logic [1:0] c_M2_ZERO = 2'b01;
    localparam logic [1:0] c_M2_ONE = 2'b10;
    localparam logic [1:0] c_M2_B   = 2'b11;

    // m4 : internal memory address source
    localparam logic [1:0] c_M4_I   = 2'b00;
    localparam logic [1:0] c_M4_J   = 2'b01;
    localparam logic [1:0] c_M4_K   = 2'b10;
    localparam logic [1:0] c_M4_N1  = 2'b11;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_SUB  = 2'b01,
        ALU_PASS = 2'b10,
        ALU_CMP  = 2'b11
    } alu_op_t;

endpackage : bubble_sort_pkg
`default_nettype wire

// File: rtl/bubble_sort_datapath_if.sv
`default_nettype none
// ============================================================================
// Module   : bubble_sort_datapath_if
// Purpose  : Control/status bundle between the sort controller (master) and
//            the datapath (slave), including all debug taps.
// Ports    : none (signal bundle); modports master / slave.
// Revision : 1.0 - initial release
// ============================================================================
interface bubble_sort_datapath_if #(
    parameter int data_in_width = 16,
    parameter int N             = 16
);
    // external data / address
    logic [data_in_width-1:0] data_in;
    logic [N-1:0]             addr_ptr;
    // memory and eoc control
    logic                     RW_MEM;
    logic                     mem_en;
    logic                     clear_eoc;
    logic                     preset_eoc;
    // register loads
    logic                     ld_a, ld_b, ld_i, ld_j, ld_k, ld_n_1;
    // mux selects
    logic                     sel_m3, sel_m5, sel_m6, sel_m7, sel_m8;
    logic [1:0]               sel_m1, sel_m2, sel_m4;
    logic [1:0]               ALU_sel;
    // status
    logic                     eoc_out;
    logic                     in_1_eq_in_2, in_1_gt_in_2, in_1_lt_in_2;
    logic [data_in_width-1:0] data_out;
    // debug taps
    logic [N-1:0]             tout_n_1, tout_i, tout_j;
    logic [data_in_width-1:0] tout_a, tout_b, tout_k, ALU_out;
    logic [N-1:0]             mux2x1_out_m8;
    logic [data_in_width-1:0] mux2x1_out_m3, mux2x1_out_m5, mux2x1_out_m6, mux2x1_out_m7;
    logic [data_in_width-1:0] mux4x1_out_m1, mux4x1_out_m2, mux4x1_out_m4;

    modport master (
        output data_in, addr_ptr, RW_MEM, mem_en, clear_eoc, preset_eoc,
        output ld_a, ld_b, ld_i, ld_j, ld_k, ld_n_1,
        output sel_m3, sel_m5, sel_m6, sel_m7, sel_m8, sel_m1, sel_m2, sel_m4, ALU_sel,
        input  eoc_out, in_1_eq_in_2, in_1_gt_in_2, in_1_lt_in_2, data_out,
        input  tout_n_1, tout_i, tout_j, tout_a, tout_b, tout_k, ALU_out,
        input  mux2x1_out_m8, mux2x1_out_m3, mux2x1_out_m5, mux2x1_out_m6, mux2x1_out_m7,
        input  mux4x1_out_m1, mux4x1_out_m2, mux4x1_out_m4
    );

    modport slave (
        input  data_in, addr_ptr, RW_MEM, mem_en, clear_eoc, preset_eoc,
        input  ld_a, ld_b, ld_i, ld_j, ld_k, ld_n_1,
        input  sel_m3, sel_m5, sel_m6, sel_m7, sel_m8, sel_m1, sel_m2, sel_m4, ALU_sel,
        output eoc_out, in_1_eq_in_2, in_1_gt_in_2, in_1_lt_in_2, data_out,
        output tout_n_1, tout_i, tout_j, tout_a, tout_b, tout_k, ALU_out,
        output mux2x1_out_m8, mux2x1_out_m3, mux2x1_out_m5, mux2x1_out_m6, mux2x1_out_m7,
        output mux4x1_out_m1, mux4x1_out_m2, mux4x1_out_m4
    );
endinterface : bubble_sort_datapath_if
`default_nettype wire

// File: rtl/bubble_sort_alu.sv
`default_nettype none
// ============================================================================
// Module   : bubble_sort_alu
// Purpose  : Shared add/sub/pass unit plus unsigned eq/gt/lt comparator.
// Ports    : in_1, in_2 (DW operands), alu_sel (op code)
//            alu_out (DW result, modulo 2^DW), eq/gt/lt (one-hot flags)
// Revision : 1.0 - initial release
// ============================================================================
module bubble_sort_alu
    import bubble_sort_pkg::*;
#(
    parameter int data_in_width = 16
) (
    input  wire logic [data_in_width-1:0] in_1,
    input  wire logic [data_in_width-1:0] in_2,
    input  wire logic [1:0]               alu_sel,
    output logic      [data_in_width-1:0] alu_out,
    output logic                          eq,
    output logic                          gt,
    output logic                          lt
);

    always_comb begin
        alu_out = '0;
        case (alu_op_t'(alu_sel))
            ALU_ADD:  alu_out = in_1 + in_2;
            ALU_SUB:  alu_out = in_1 - in_2;
            ALU_PASS: alu_out = in_2;
            ALU_CMP:  alu_out = '0;
            default:  alu_out = '0;
        endcase
    end

    // Flags are independent of the op code so the controller can branch
    // during any ALU operation.
    assign eq = (in_1 == in_2);
    assign gt = (in_1 >  in_2);
    assign lt = (in_1 <  in_2);

endmodule : bubble_sort_alu
`default_nettype wire

// File: rtl/bubble_sort_datapath.sv
`default_nettype none
// ============================================================================
// Module   : bubble_sort_datapath
// Purpose  : Datapath of the top-down bubble-sort engine: data memory, a/b
//            data registers, i/j/k/n_1 index registers, shared ALU and the
//            mux network, steered by an external controller.
// Ports    : clk, rst (synchronous, active-high)
//            dp   - bubble_sort_datapath_if.slave (controls, flags, taps)
// Config   : DP_N1_FROM_INPUT_EN - when defined, ld_n_1 loads
//            data_in[N-1:0]-1; otherwise NUM_ELEM-1.
// Revision : 1.0 - initial release
// ============================================================================
module bubble_sort_datapath
    import bubble_sort_pkg::*;
#(
    parameter int data_in_width = 16,
    parameter int N             = 16,
    parameter int MEM_DEPTH     = 16,
    parameter int NUM_ELEM      = 8
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    bubble_sort_datapath_if.slave        dp
);

    localparam int c_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [data_in_width-1:0] r_a, r_b, r_k;
    logic [N-1:0]             r_i, r_j, r_n_1;
    logic                     r_eoc;
    logic [data_in_width-1:0] r_mem [MEM_DEPTH];

    logic [data_in_width-1:0] w_m1, w_m2, w_m3, w_m5, w_m6, w_m7, w_alu_out, w_data_out;
    logic [N-1:0]             w_m4, w_m8, w_n_1_next;
    logic [c_AW-1:0]          w_addr;
    logic                     w_wr, w_rd;

    // ALU operand muxes; N-wide indices are resized to the data width.
    always_comb begin
        w_m1 = '0;
        case (dp.sel_m1)
            c_M1_I:  w_m1 = data_in_width'(r_i);
            c_M1_J:  w_m1 = data_in_width'(r_j);
            c_M1_K:  w_m1 = r_k;
            default: w_m1 = r_a;
        endcase
    end

    always_comb begin
        w_m2 = '0;
        case (dp.sel_m2)
            c_M2_N1:   w_m2 = data_in_width'(r_n_1);
            c_M2_ZERO: w_m2 = '0;
            c_M2_ONE:  w_m2 = data_in_width'(1);
            default:   w_m2 = r_b;
        endcase
    end

    always_comb begin
        w_m4 = '0;
        case (dp.sel_m4)
            c_M4_I:  w_m4 = r_i;
            c_M4_J:  w_m4 = r_j;
            c_M4_K:  w_m4 = N'(r_k);
            default: w_m4 = r_n_1;
        endcase
    end

    assign w_m8 = dp.sel_m8 ? dp.addr_ptr : w_m4;
    assign w_m3 = dp.sel_m3 ? r_b : r_a;
    assign w_m7 = dp.sel_m7 ? dp.data_in : w_m3;
    // Note the opposite polarity of m5 and m6 for the constant-zero leg.
    assign w_m5 = dp.sel_m5 ? '0 : w_alu_out;
    assign w_m6 = dp.sel_m6 ? w_alu_out : '0;

    // Upper address bits are dropped, so addresses wrap around the memory.
    assign w_addr = w_m8[c_AW-1:0];
    assign w_wr   = dp.mem_en &  dp.RW_MEM;
    assign w_rd   = dp.mem_en & ~dp.RW_MEM;

    assign w_data_out = w_rd ? r_mem[w_addr] : '0;

`ifdef DP_N1_FROM_INPUT_EN
    assign w_n_1_next = N'(dp.data_in) - N'(1);
`else
    assign w_n_1_next = N'(NUM_ELEM - 1);
`endif

    bubble_sort_alu #(
        .data_in_width (data_in_width)
    ) u_alu (
        .in_1    (w_m1),
        .in_2    (w_m2),
        .alu_sel (dp.ALU_sel),
        .alu_out (w_alu_out),
        .eq      (dp.in_1_eq_in_2),
        .gt      (dp.in_1_gt_in_2),
        .lt      (dp.in_1_lt_in_2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_k   <= '0;
            r_i   <= '0;
            r_j   <= '0;
            r_n_1 <= '0;
            r_eoc <= 1'b0;
            for (int w = 0; w < MEM_DEPTH; w++) begin
                r_mem[w] <= '0;
            end
        end else begin
            if (dp.ld_a)   r_a   <= w_data_out;
            if (dp.ld_b)   r_b   <= w_data_out;
            if (dp.ld_k)   r_k   <= w_alu_out;
            if (dp.ld_i)   r_i   <= N'(w_m5);
            if (dp.ld_j)   r_j   <= N'(w_m6);
            if (dp.ld_n_1) r_n_1 <= w_n_1_next;
            if (dp.preset_eoc)     r_eoc <= 1'b1;
            else if (dp.clear_eoc) r_eoc <= 1'b0;
            if (w_wr) r_mem[w_addr] <= w_m7;
        end
    end

    assign dp.eoc_out       = r_eoc;
    assign dp.data_out      = w_data_out;
    assign dp.tout_n_1      = r_n_1;
    assign dp.tout_i        = r_i;
    assign dp.tout_j        = r_j;
    assign dp.tout_a        = r_a;
    assign dp.tout_b        = r_b;
    assign dp.tout_k        = r_k;
    assign dp.ALU_out       = w_alu_out;
    assign dp.mux2x1_out_m8 = w_m8;
    assign dp.mux2x1_out_m3 = w_m3;
    assign dp.mux2x1_out_m5 = w_m5;
    assign dp.mux2x1_out_m6 = w_m6;
    assign dp.mux2x1_out_m7 = w_m7;
    assign dp.mux4x1_out_m1 = w_m1;
    assign dp.mux4x1_out_m2 = w_m2;
    assign dp.mux4x1_out_m4 = data_in_width'(w_m4);

endmodule : bubble_sort_datapath
`default_nettype wire

// File: tb/tb_bubble_sort_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_bubble_sort_datapath
// Purpose  : Self-checking bench for bubble_sort_datapath. Memory read-backs
//            are checked against a queue of expected words pushed when the
//            matching writes are issued.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bubble_sort_datapath;

    localparam int DW = 16;
    localparam int NW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] exp_w;

    bubble_sort_datapath_if #(.data_in_width(DW), .N(NW)) ifc ();

    bubble_sort_datapath #(
        .data_in_width (DW),
        .N             (NW),
        .MEM_DEPTH     (16),
        .NUM_ELEM      (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .dp  (ifc)
    );

    always #5 clk = ~clk;

    // Advance one active edge and settle 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifc.data_in = '0; ifc.addr_ptr = '0; ifc.RW_MEM = 0; ifc.mem_en = 0;
        ifc.clear_eoc = 0; ifc.preset_eoc = 0;
        ifc.ld_a = 0; ifc.ld_b = 0; ifc.ld_i = 0; ifc.ld_j = 0; ifc.ld_k = 0; ifc.ld_n_1 = 0;
        ifc.sel_m3 = 0; ifc.sel_m5 = 0; ifc.sel_m6 = 0; ifc.sel_m7 = 0; ifc.sel_m8 = 0;
        ifc.sel_m1 = 0; ifc.sel_m2 = 0; ifc.sel_m4 = 0; ifc.ALU_sel = 0;
    endtask

    // Read n words starting at base via addr_ptr; compare against the queue.
    task automatic read_back(input int base, input int n, input string tag);
        idle();
        ifc.mem_en = 1; ifc.RW_MEM = 0; ifc.sel_m8 = 1;
        for (int r = 0; r < n; r++) begin
            ifc.addr_ptr = NW'(base + r);
            #1;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL %s_sb_empty: addr %0d got %0h, no expected word", tag, base + r, ifc.data_out);
            end else begin
                exp_w = exp_q.pop_front();
                if (ifc.data_out !== exp_w) begin
                    n_errors++;
                    $display("FAIL %s_mem[%0d]: got %0h exp %0h", tag, base + r, ifc.data_out, exp_w);
                end
            end
        end
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        repeat (10) step();
        n_checks++;
        if ({ifc.eoc_out, ifc.tout_a, ifc.tout_b, ifc.tout_k, ifc.tout_i, ifc.tout_j, ifc.tout_n_1} !== '0) begin
            n_errors++;
            $display("FAIL reset_regs: eoc=%0b a=%0h b=%0h k=%0h i=%0h j=%0h n1=%0h exp all 0",
                     ifc.eoc_out, ifc.tout_a, ifc.tout_b, ifc.tout_k, ifc.tout_i, ifc.tout_j, ifc.tout_n_1);
        end
        rst = 0;
    endtask

    task automatic test_load();
        idle();
        ifc.mem_en = 1; ifc.RW_MEM = 1; ifc.sel_m7 = 1; ifc.sel_m8 = 1;
        for (int w = 0; w < 8; w++) begin
            ifc.addr_ptr = NW'(w);
            ifc.data_in  = DW'(w + 2);
            exp_q.push_back(DW'(w + 2));
            step();
        end
        read_back(0, 8, "load");
        // Upper address bits ignored: 18 aliases word 2, 23 aliases word 7.
        exp_q.push_back(16'd4);
        read_back(18, 1, "wrap");
        exp_q.push_back(16'd9);
        read_back(23, 1, "wrap");
        // Enabled write-mode and disabled memory both drive data_out to 0.
        ifc.mem_en = 0; ifc.addr_ptr = 16'd3; #1;
        n_checks++;
        if (ifc.data_out !== 16'd0) begin
            n_errors++;
            $display("FAIL rd_disabled: got %0h exp 0", ifc.data_out);
        end
        idle();
    endtask

    task automatic test_init();
        idle();
        ifc.clear_eoc = 1; ifc.ld_j = 1; ifc.sel_m6 = 0; ifc.ld_n_1 = 1;
        ifc.data_in = 16'd8;   // runtime count in the input-loaded build
        step();
        idle();
        n_checks++;
        if (ifc.tout_j !== 16'd0 || ifc.tout_n_1 !== 16'd7 || ifc.eoc_out !== 1'b0) begin
            n_errors++;
            $display("FAIL init: j=%0h n1=%0h eoc=%0b exp j=0 n1=7 eoc=0", ifc.tout_j, ifc.tout_n_1, ifc.eoc_out);
        end
        ifc.preset_eoc = 1; step(); idle();
        n_checks++;
        if (ifc.eoc_out !== 1'b1) begin
            n_errors++;
            $display("FAIL eoc_preset: got %0b exp 1", ifc.eoc_out);
        end
        ifc.clear_eoc = 1; step(); idle();
        n_checks++;
        if (ifc.eoc_out !== 1'b0) begin
            n_errors++;
            $display("FAIL eoc_clear: got %0b exp 0", ifc.eoc_out);
        end
        ifc.clear_eoc = 1; ifc.preset_eoc = 1; step(); idle();
        n_checks++;
        if (ifc.eoc_out !== 1'b1) begin
            n_errors++;
            $display("FAIL eoc_both: got %0b exp 1", ifc.eoc_out);
        end
        step();
        n_checks++;
        if (ifc.eoc_out !== 1'b1) begin
            n_errors++;
            $display("FAIL eoc_hold: got %0b exp 1", ifc.eoc_out);
        end
    endtask

    task automatic test_compare();
        idle();
        ifc.sel_m1 = 2'b01; ifc.sel_m2 = 2'b00; #1;   // j=0 vs n_1=7
        n_checks++;
        if ({ifc.in_1_eq_in_2, ifc.in_1_gt_in_2, ifc.in_1_lt_in_2} !== 3'b001) begin
            n_errors++;
            $display("FAIL cmp_j_n1: eq/gt/lt=%03b exp 001", {ifc.in_1_eq_in_2, ifc.in_1_gt_in_2, ifc.in_1_lt_in_2});
        end
        ifc.sel_m2 = 2'b01; #1;                        // j=0 vs 0
        n_checks++;
        if ({ifc.in_1_eq_in_2, ifc.in_1_gt_in_2, ifc.in_1_lt_in_2} !== 3'b100) begin
            n_errors++;
            $display("FAIL cmp_eq: eq/gt/lt=%03b exp 100", {ifc.in_1_eq_in_2, ifc.in_1_gt_in_2, ifc.in_1_lt_in_2});
        end
        idle();
        ifc.sel_m5 = 1; ifc.ld_i = 1; step(); idle();
        n_checks++;
        if (ifc.tout_i !== 16'd0) begin
            n_errors++;
            $display("FAIL i_zero: got %0h exp 0", ifc.tout_i);
        end
    endtask

    task automatic test_index();
        idle();
        ifc.sel_m1 = 2'b00; ifc.sel_m2 = 2'b10; ifc.ALU_sel = 2'b00; ifc.ld_k = 1; #1;
        n_checks++;
        if (ifc.ALU_out !== 16'd1) begin
            n_errors++;
            $display("FAIL alu_add: got %0h exp 1", ifc.ALU_out);
        end
        step(); idle();
        n_checks++;
        if (ifc.tout_k !== 16'd1) begin
            n_errors++;
            $display("FAIL k_load: got %0h exp 1", ifc.tout_k);
        end
        ifc.sel_m1 = 2'b10; ifc.sel_m2 = 2'b01; #1;   // k=1 vs 0
        n_checks++;
        if ({ifc.in_1_eq_in_2, ifc.in_1_gt_in_2, ifc.in_1_lt_in_2} !== 3'b010) begin
            n_errors++;
            $display("FAIL cmp_gt: eq/gt/lt=%03b exp 010", {ifc.in_1_eq_in_2, ifc.in_1_gt_in_2, ifc.in_1_lt_in_2});
        end
        idle();
        ifc.mem_en = 1; ifc.RW_MEM = 0; ifc.sel_m8 = 0; ifc.sel_m4 = 2'b00; ifc.ld_a = 1;
        step();
        ifc.ld_a = 0; ifc.sel_m4 = 2'b10; ifc.ld_b = 1;
        step(); idle();
        n_checks++;
        if (ifc.tout_a !== 16'd2 || ifc.tout_b !== 16'd3) begin
            n_errors++;
            $display("FAIL ab_load: a=%0h b=%0h exp a=2 b=3", ifc.tout_a, ifc.tout_b);
        end
    endtask

    task automatic test_swap();
        idle();
        ifc.sel_m1 = 2'b11; ifc.sel_m2 = 2'b11; #1;   // a=2 vs b=3
        n_checks++;
        if (ifc.in_1_lt_in_2 !== 1'b1 || ifc.in_1_gt_in_2 !== 1'b0 || ifc.in_1_eq_in_2 !== 1'b0) begin
            n_errors++;
            $display("FAIL cmp_ab: eq/gt/lt=%0b%0b%0b exp 001", ifc.in_1_eq_in_2, ifc.in_1_gt_in_2, ifc.in_1_lt_in_2);
        end
        ifc.ALU_sel = 2'b01; #1;                        // 2-3 wraps
        n_checks++;
        if (ifc.ALU_out !== 16'hFFFF) begin
            n_errors++;
            $display("FAIL alu_sub_wrap: got %0h exp ffff", ifc.ALU_out);
        end
        ifc.ALU_sel = 2'b10; #1;
        n_checks++;
        if (ifc.ALU_out !== 16'd3) begin
            n_errors++;
            $display("FAIL alu_pass: got %0h exp 3", ifc.ALU_out);
        end
        ifc.ALU_sel = 2'b11; #1;
        n_checks++;
        if (ifc.ALU_out !== 16'd0 || ifc.in_1_lt_in_2 !== 1'b1) begin
            n_errors++;
            $display("FAIL alu_cmp: out=%0h lt=%0b exp out=0 lt=1", ifc.ALU_out, ifc.in_1_lt_in_2);
        end
        idle();
        ifc.mem_en = 1; ifc.RW_MEM = 1; ifc.sel_m7 = 0; ifc.sel_m8 = 0;
        ifc.sel_m3 = 1; ifc.sel_m4 = 2'b00; step();      // b -> mem[i=0]
        ifc.sel_m3 = 0; ifc.sel_m4 = 2'b10; step();      // a -> mem[k=1]
        exp_q.push_back(16'd3);
        exp_q.push_back(16'd2);
        exp_q.push_back(16'd4);
        read_back(0, 3, "swap");
        // i <= ALU_out (i+1) via m5=0, j <= ALU_out via m6=1.
        ifc.sel_m1 = 2'b00; ifc.sel_m2 = 2'b10; ifc.ALU_sel = 2'b00;
        ifc.sel_m5 = 0; ifc.ld_i = 1; ifc.sel_m6 = 1; ifc.ld_j = 1;
        step(); idle();
        n_checks++;
        if (ifc.tout_i !== 16'd1 || ifc.tout_j !== 16'd1) begin
            n_errors++;
            $display("FAIL ij_from_alu: i=%0h j=%0h exp 1 1", ifc.tout_i, ifc.tout_j);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        ifc.preset_eoc = 1; step();
        ifc.preset_eoc = 0;
        ifc.mem_en = 1; ifc.RW_MEM = 1; ifc.sel_m7 = 1; ifc.sel_m8 = 1;
        ifc.addr_ptr = 16'd5; ifc.data_in = 16'hAAAA;
        ifc.ld_a = 1; ifc.ld_k = 1; ifc.ld_n_1 = 1;
        rst = 1;
        step();
        rst = 0;
        idle();
        n_checks++;
        if ({ifc.eoc_out, ifc.tout_a, ifc.tout_b, ifc.tout_k, ifc.tout_i, ifc.tout_j, ifc.tout_n_1} !== '0) begin
            n_errors++;
            $display("FAIL midrst_regs: eoc=%0b a=%0h b=%0h k=%0h i=%0h j=%0h n1=%0h exp all 0",
                     ifc.eoc_out, ifc.tout_a, ifc.tout_b, ifc.tout_k, ifc.tout_i, ifc.tout_j, ifc.tout_n_1);
        end
        for (int w = 0; w < 8; w++) exp_q.push_back(16'd0);
        read_back(0, 8, "midrst");
    endtask

    initial begin
        idle();
        test_reset();
        test_load();
        test_init();
        test_compare();
        test_index();
        test_swap();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_leftover: got %0d entries exp 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_bubble_sort_datapath
`default_nettype wire
